// File: rtl/instru_mem_loader_pkg.sv
// Shared constants and FSM encoding for the instruction memory loader.
// No logic; no latency; no backpressure.
// Widths are fixed by the 6-bit PC fetch port and the 128-byte store.
package instru_mem_loader_pkg;
    localparam int DEPTH       = 128;
    localparam int AW          = 7;
    localparam int DW          = 8;
    localparam int INSTR_BYTES = 4;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_LOAD   = 2'd1;
    localparam state_t ST_FINISH = 2'd2;
endpackage

// File: rtl/instru_mem_loader_if.sv
// Byte stream handshake into the loader.
// No latency; no logic.
// Backpressure: the slave drops in_ready whenever it is not loading.
interface instru_mem_loader_if #(parameter int DW = 8);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;

    modport master (output in_valid, output in_data, input  in_ready);
    modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/instru_store.sv
// Register-array instruction store: one synchronous write port, NRD async read ports.
// Latency: write visible after the clock edge; reads are combinational.
// Backpressure: none, every write enable is committed.
module instru_store #(
    parameter int DEPTH = 128,
    parameter int AW    = 7,
    parameter int DW    = 8,
    parameter int NRD   = 4
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [AW-1:0]           wr_addr,
    input  logic [DW-1:0]           wr_data,
    input  logic [NRD-1:0][AW-1:0]  rd_addr,
    output logic [NRD-1:0][DW-1:0]  rd_data
);
    // No reset: program contents must survive a core reset.
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        assign rd_data[k] = mem[rd_addr[k]];
    end
endmodule

// File: rtl/instru_mem_loader.sv
// Loads a byte stream into the instruction store and serves 4-byte fetches.
// Latency: byte written on the accepting edge; done pulses the cycle after the last byte.
// Backpressure: in_ready is high only while loading; no timeout on a stalled stream.
module instru_mem_loader #(
    parameter int DEPTH = instru_mem_loader_pkg::DEPTH,
    parameter int AW    = instru_mem_loader_pkg::AW,
    parameter int DW    = instru_mem_loader_pkg::DW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [AW-1:0]           base_addr,
    input  logic [7:0]              length,
    instru_mem_loader_if.slave      in_if,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [7:0]              checksum,
    input  logic [5:0]              Direccion,
    output logic [DW-1:0]           B1,
    output logic [DW-1:0]           B2,
    output logic [DW-1:0]           B3,
    output logic [DW-1:0]           B4
);
    import instru_mem_loader_pkg::*;

    state_t                          state;
    logic [AW-1:0]                   wr_ptr;
    logic [7:0]                      remaining;
    logic                            len_ok;
    logic                            xfer;
    logic [INSTR_BYTES-1:0][AW-1:0]  rd_addr;
    logic [INSTR_BYTES-1:0][DW-1:0]  rd_data;

    assign len_ok         = (length != 8'd0) && ({1'b0, length} <= 9'(DEPTH));
    assign in_if.in_ready = (state == ST_LOAD);
    assign busy           = (state == ST_LOAD);
    assign done           = (state == ST_FINISH);
    // Abort wins over a same-cycle byte, so that byte is never written.
    assign xfer           = (state == ST_LOAD) && in_if.in_valid && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            wr_ptr    <= '0;
            remaining <= '0;
            checksum  <= '0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (len_ok) begin
                            state     <= ST_LOAD;
                            wr_ptr    <= base_addr;
                            remaining <= length;
                            checksum  <= '0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (in_if.in_valid) begin
                        wr_ptr    <= wr_ptr + AW'(1);
                        remaining <= remaining - 8'd1;
                        checksum  <= checksum ^ 8'(in_if.in_data);
                        if (remaining == 8'd1) begin
                            state <= ST_FINISH;
                        end
                    end
                end
                ST_FINISH: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // Fetch addresses never exceed 63+3, so the 7-bit sum needs no wrap handling.
    for (genvar k = 0; k < INSTR_BYTES; k++) begin : g_fetch
        assign rd_addr[k] = AW'(Direccion) + AW'(k);
    end

    instru_store #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW),
        .NRD   (INSTR_BYTES)
    ) u_store (
        .clk     (clk),
        .we      (xfer),
        .wr_addr (wr_ptr),
        .wr_data (in_if.in_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign B1 = rd_data[0];
    assign B2 = rd_data[1];
    assign B3 = rd_data[2];
    assign B4 = rd_data[3];
endmodule

// File: tb/tb_instru_mem_loader.sv
// Directed and randomized checks of the loader against a byte-array model.
module tb_instru_mem_loader;
    logic       clk = 1'b0;
    logic       rst_n, start, abort;
    logic [6:0] base_addr;
    logic [7:0] length;
    logic       busy, done, err;
    logic [7:0] checksum;
    logic [5:0] Direccion;
    logic [7:0] B1, B2, B3, B4;

    always #5 clk = ~clk;

    instru_mem_loader_if #(.DW(8)) in_if();

    instru_mem_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .length    (length),
        .in_if     (in_if.slave),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .checksum  (checksum),
        .Direccion (Direccion),
        .B1        (B1),
        .B2        (B2),
        .B3        (B3),
        .B4        (B4)
    );

    logic [7:0] ref_mem [128];
    logic [7:0] ref_cs;
    logic [7:0] dq [$];
    int ncmp  = 0;
    int nfail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < 64; a++) begin
            @(negedge clk);
            Direccion = 6'(a);
            #1;
            chk(tag, {B1, B2, B3, B4}, {ref_mem[a], ref_mem[a+1], ref_mem[a+2], ref_mem[a+3]});
        end
    endtask

    // abort_k: index of the valid byte that carries abort (-1 for none).
    task automatic run_load(input logic [6:0] b, input int n, input int gap_pct,
                            input logic [15:0] vpat, input int vpat_len, input int abort_k);
        int         sent, cyc;
        logic       v;
        logic [7:0] d;
        logic [6:0] p;
        bit         aborted;
        sent = 0; cyc = 0; p = b; aborted = 0;
        @(negedge clk);
        start = 1'b1; base_addr = b; length = 8'(n);
        @(negedge clk);
        start = 1'b0;
        chk("load_busy", busy, 1);
        chk("load_ready", in_if.in_ready, 1);
        ref_cs = 8'h00;
        while (sent < n && !aborted && cyc < 1000) begin
            if (vpat_len > 0) v = (cyc < vpat_len) ? vpat[cyc] : 1'b1;
            else              v = ($urandom_range(99) >= gap_pct);
            if (sent == abort_k) v = 1'b1;
            if (v && dq.size() > 0) d = dq.pop_front();
            else                    d = 8'($urandom);
            in_if.in_valid = v;
            in_if.in_data  = d;
            abort          = (sent == abort_k);
            @(negedge clk);
            cyc++;
            if (sent == abort_k) begin
                aborted = 1;
                chk("abort_busy", busy, 0);
                chk("abort_no_done", done, 0);
            end else if (v) begin
                ref_mem[p] = d;
                p = p + 7'd1;
                ref_cs = ref_cs ^ d;
                sent++;
                if (sent == n) chk("done_pulse", done, 1);
                else           chk("no_early_done", done, 0);
            end else begin
                chk("hold_busy", busy, 1);
            end
        end
        in_if.in_valid = 1'b0;
        abort = 1'b0;
        ncmp++;
        assert (cyc < 1000) else begin
            nfail++;
            $error("FAIL load_timeout: observed %0d cycles expected < 1000", cyc);
        end
        @(negedge clk);
        chk("done_single", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_ready", in_if.in_ready, 0);
        chk("checksum", checksum, ref_cs);
    endtask

    initial begin
        int         lens [3];
        logic [7:0] old_b, nb, d2, a0, a1;
        int         n, ak;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; length = '0;
        in_if.in_valid = 1'b0; in_if.in_data = '0; Direccion = '0;
        ref_cs = 8'h00;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_if.in_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_checksum", checksum, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill the whole store (maximum legal length) so the model is fully known.
        run_load(7'd0, 128, 30, 16'h0, 0, -1);
        sweep("init_mem");

        dq = '{8'h12, 8'h34, 8'h56, 8'h78};
        run_load(7'd0, 4, 0, 16'h0, 0, -1);
        @(negedge clk);
        Direccion = 6'd0;
        #1;
        chk("basic_fetch", {B1, B2, B3, B4}, 32'h12345678);
        chk("basic_checksum", checksum, 8'h08);

        // Valid pattern 1,0,1,1,0,1 across the 127->0 wrap.
        run_load(7'd126, 4, 0, 16'h002D, 6, -1);
        @(negedge clk);
        Direccion = 6'd0;
        #1;
        chk("wrap_fetch", {B1, B2, B3}, {ref_mem[0], ref_mem[1], ref_mem[2]});

        lens = '{0, 200, 129};
        foreach (lens[i]) begin
            @(negedge clk);
            start = 1'b1; base_addr = 7'd3; length = 8'(lens[i]);
            @(negedge clk);
            start = 1'b0;
            chk("illegal_err", err, 1);
            chk("illegal_busy", busy, 0);
            chk("illegal_checksum", checksum, ref_cs);
            @(negedge clk);
            chk("illegal_err_clear", err, 0);
        end
        sweep("after_illegal");

        run_load(7'd10, 8, 20, 16'h0, 0, 2);
        run_load(7'd20, 3, 0, 16'h0, 0, -1);
        sweep("after_abort");

        // Read/write collision plus a start that must be ignored mid-load.
        @(negedge clk);
        start = 1'b1; base_addr = 7'd5; length = 8'd2;
        @(negedge clk);
        old_b = ref_mem[5];
        nb = ~old_b;
        Direccion = 6'd4;
        in_if.in_valid = 1'b1; in_if.in_data = nb;
        start = 1'b1; length = 8'd0;
        #1;
        chk("coll_old", B2, old_b);
        @(negedge clk);
        ref_mem[5] = nb;
        chk("coll_new", B2, nb);
        chk("start_in_load_no_err", err, 0);
        chk("coll_busy", busy, 1);
        start = 1'b0;
        d2 = 8'($urandom);
        in_if.in_data = d2;
        @(negedge clk);
        ref_mem[6] = d2;
        ref_cs = nb ^ d2;
        chk("coll_done", done, 1);
        in_if.in_valid = 1'b0;
        @(negedge clk);
        chk("coll_done_clear", done, 0);
        chk("coll_checksum", checksum, ref_cs);
        sweep("after_coll");

        // Asynchronous reset after 2 of 4 bytes.
        @(negedge clk);
        start = 1'b1; base_addr = 7'd40; length = 8'd4;
        @(negedge clk);
        start = 1'b0;
        a0 = 8'($urandom); a1 = 8'($urandom);
        in_if.in_valid = 1'b1; in_if.in_data = a0;
        @(negedge clk);
        ref_mem[40] = a0;
        in_if.in_data = a1;
        @(negedge clk);
        ref_mem[41] = a1;
        in_if.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", in_if.in_ready, 0);
        chk("midrst_checksum", checksum, 0);
        chk("midrst_done", done, 0);
        ref_cs = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        sweep("after_reset");

        for (int it = 0; it < 6; it++) begin
            n  = $urandom_range(24, 1);
            ak = ($urandom_range(3) == 0) ? int'($urandom_range(n - 1, 0)) : -1;
            run_load(7'($urandom), n, 40, 16'h0, 0, ak);
            sweep("random_load");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/instru_mem_loader.md
Name: instru_mem_loader

Overview:
Writable instruction memory for the processor, with a loader front end.
- Accepts a byte stream over a valid/ready handshake and writes it into a 128 x 8 instruction store starting at a programmable base address.
- Exposes the same 4-byte fetch read port the core uses: 6-bit PC address in, bytes B1..B4 out.
- Lets programs be loaded at run time (from UART/host bridge) instead of only by file initialisation.

Parameters:
DEPTH, 128, number of byte locations in the store
AW, 7, byte address width (log2 DEPTH)
DW, 8, data width of one location

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a load (sampled in IDLE only)
abort  input  1  terminate an active load
base_addr  input  AW  first byte address of the load
length  input  8  number of bytes to load, legal 1..DEPTH
in_valid  input  1  in_data holds a byte
in_data  input  DW  byte to write
in_ready  output  1  loader accepts a byte this cycle
busy  output  1  load in progress
done  output  1  one-cycle pulse: load completed
err  output  1  one-cycle pulse: illegal start request
checksum  output  8  running XOR of bytes accepted in the current/last load
Direccion  input  6  fetch address (PC)
B1  output  DW  mem[Direccion], most significant instruction byte
B2  output  DW  mem[Direccion+1]
B3  output  DW  mem[Direccion+2]
B4  output  DW  mem[Direccion+3], least significant instruction byte

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; in_ready, busy, done, err = 0; checksum = 0; write pointer and remaining count = 0.
- Reset does not clear memory contents.
- States: IDLE, LOAD, FINISH.
- IDLE, start=1, length in 1..128:
  - next state LOAD; wr_ptr <= base_addr; remaining <= length; checksum <= 0.
- IDLE, start=1, length=0 or length>128:
  - err=1 for one cycle; stay IDLE; memory and checksum untouched.
- LOAD:
  - in_ready=1, busy=1.
  - Transfer when in_valid & in_ready: mem[wr_ptr] <= in_data; wr_ptr <= wr_ptr+1 (mod 128, wraps 127->0); remaining <= remaining-1; checksum <= checksum ^ in_data.
  - Transfer with remaining=1: next state FINISH.
  - No in_valid: hold; no timeout.
- FINISH: done=1 for exactly one cycle; busy=0; in_ready=0; next state IDLE.
- abort in LOAD:
  - Takes priority over a same-cycle transfer; that byte is not written.
  - Next state IDLE, no done.
  - Bytes already written stay; checksum holds its partial value.
- start while LOAD or FINISH: ignored, no err.
- in_ready=0 outside LOAD; in_valid there is ignored.
- Read port:
  - Combinational, no clock.
  - Addresses formed as 7-bit sums Direccion+k, k=0..3 (max 66, no wrap).
  - Reads return committed contents. A byte written on edge N is visible on the read port after edge N; the same-cycle read shows the old value.
- Single write port and four read ports. Implement as a register array (not block RAM) because of the 4 async reads.

Decomposition:
- Shared package:
  - state encoding typedef (IDLE/LOAD/FINISH)
  - DEPTH/AW/DW constants
  - instruction width constant INSTR_BYTES=4
- Sub-module instru_store:
  - register array, one synchronous write port, four combinational read ports
  - shares DEPTH/AW/DW
- The loader FSM, counters and checksum stay in the top.

Test Plan:
- Reset: assert rst_n=0 mid-LOAD after 2 of 4 bytes -> immediately busy=0, in_ready=0, checksum=0; bytes 0,1 retained; no done.
- Basic load: base_addr=0, length=4, bytes 8'h12,8'h34,8'h56,8'h78 back-to-back -> done pulse the cycle after the 4th transfer; Direccion=0 gives B1..B4=12,34,56,78; checksum=8'h08.
- Backpressure/wrap: base_addr=126, length=4, in_valid toggling 1,0,1,1,0,1 -> exactly 4 writes at addresses 126,127,0,1; done once; wr_ptr wraps cleanly.
- Illegal start: length=0, then length=200 -> err=1 one cycle each; busy stays 0; memory unchanged.
- Abort: length=8, abort asserted together with the 3rd valid byte -> only 2 bytes written, 3rd address unchanged, state IDLE, no done; next start is accepted normally.
- Read/write collision: Direccion=4 while writing address 5 -> B2 shows old value that cycle and the new value after the edge; start during LOAD is ignored.
